onehot_updown_counter: RTL



---
 rtl/onehot_updown_counter_pkg.sv | 20 ++
 rtl/onehot_encoder.sv | 28 ++
 rtl/onehot_updown_counter.sv | 87 ++++++++
 3 files changed

// File: rtl/onehot_updown_counter_pkg.sv
// Shared constants and helpers for the bidirectional one-hot counter.
package onehot_updown_counter_pkg;

  localparam logic DirUp   = 1'b1;
  localparam logic DirDown = 1'b0;

  // Bit position held after reset and after any recovery.
  localparam int unsigned ResetBit = 0;

  // Index width for an n-state counter; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder with a popcount==1 valid flag; purely combinational.
module onehot_encoder
  import onehot_updown_counter_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = clog2_min1(N)
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int unsigned ones;

  always_comb begin
    idx_o = '0;
    ones  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        // Only meaningful when exactly one bit is set; callers gate with valid_o.
        idx_o = idx_o | W'(i);
        ones  = ones + 1;
      end
    end
    valid_o = (ones == 1);
  end

endmodule

// File: rtl/onehot_updown_counter.sv
// Up/down one-hot rotating counter with index load, wrap pulse and illegal-state recovery.
module onehot_updown_counter
  import onehot_updown_counter_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = clog2_min1(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_idx,
  output logic [N-1:0] q,
  output logic [W-1:0] idx,
  output logic         wrap,
  output logic         err
);

  localparam logic [N-1:0] QReset = N'(1) << ResetBit;

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  // Every consumer of the present state reads this net, so an upset on it is seen everywhere.
  logic [N-1:0] cur_q;
  logic [W-1:0] enc_idx;
  logic         enc_valid;
  logic         load_in_range;

  assign cur_q = q_q;

  onehot_encoder #(
    .N (N),
    .W (W)
  ) u_encoder (
    .onehot_i (cur_q),
    .idx_o    (enc_idx),
    .valid_o  (enc_valid)
  );

  assign load_in_range = (32'(load_idx) < N);

  always_comb begin
    q_d    = cur_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (!enc_valid) begin
      q_d   = QReset;
      err_d = 1'b1;
    end else if (load) begin
      if (load_in_range) begin
        q_d = QReset << load_idx;
      end else begin
        q_d   = QReset;
        err_d = 1'b1;
      end
    end else if (en) begin
      if (up == DirUp) begin
        q_d    = {cur_q[N-2:0], cur_q[N-1]};
        wrap_d = cur_q[N-1];
      end else begin
        q_d    = {cur_q[0], cur_q[N-1:1]};
        wrap_d = cur_q[0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q    <= QReset;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = cur_q;
  assign idx  = enc_valid ? enc_idx : '0;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
